// File: rtl/cnt_mon_pkg.sv
// Shared types and default geometry for the counter wrap monitor.
// The event record is {wrap_idx, period}, with the period in the LSBs.
package cnt_mon_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, SYNC, RUN} state_t;

  localparam int DEF_CNT_W = 5;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_PER_W = 16;
  localparam int DEF_IDX_W = 8;
  localparam int PER_LSB   = 0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO whose head entry is presented from a register.
// A push into an empty FIFO reaches the head one cycle later; it is never bypassed.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      level_reg;
  logic [WIDTH-1:0] head_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // The new head is either the record just written into the head slot or a stored one.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
    end else if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
      head_reg <= din;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_ok);
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  assign head  = head_reg;
  assign level = level_reg;

endmodule

// File: rtl/cnt_wrap_monitor.sv
// Watches a free-running count bus, timestamps each wrap-around with the cycle period
// since the previous wrap and queues {wrap_idx, period} records for a valid/ready consumer.
module cnt_wrap_monitor
  import cnt_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PER_W = DEF_PER_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CNT_W-1:0]         cnt_in,
  input  logic                     ovf_clr,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [IDX_W+PER_W-1:0]   evt_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int REC_W   = IDX_W + PER_W;
  localparam int IDX_LSB = PER_LSB + PER_W;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_q_reg;
  logic [PER_W-1:0] period_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             ovf_reg;
  logic [REC_W-1:0] rec_data;
  logic             wrap;
  logic             rec_push;
  logic             per_load;
  logic             per_step;
  logic             per_clr;
  logic             fifo_empty;
  logic             fifo_full;

  // A stalled counter (equal value) is not a wrap.
  assign wrap = (cnt_in < cnt_q_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = PRIME;
      PRIME:   state_next = SYNC;
      SYNC:    if (wrap) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (!en) begin
      state_next = IDLE;
    end
  end

  // The first wrap after enabling only starts the period count; its period is partial.
  always_comb begin
    rec_push = 1'b0;
    per_load = 1'b0;
    per_step = 1'b0;
    per_clr  = 1'b0;
    if (!en) begin
      per_clr = 1'b1;
    end else begin
      case (state_reg)
        SYNC: per_load = wrap;
        RUN: begin
          rec_push = wrap;
          per_load = wrap;
          per_step = !wrap;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q_reg  <= '0;
      period_reg <= '0;
      idx_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      cnt_q_reg <= cnt_in;
      if (per_clr) begin
        period_reg <= '0;
      end else if (per_load) begin
        period_reg <= PER_W'(1);
      end else if (per_step && (period_reg != '1)) begin
        period_reg <= period_reg + PER_W'(1);
      end
      // Dropped records still consume an index so the consumer can see the gap.
      if (rec_push) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
      if (rec_push && fifo_full && !evt_ready) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    rec_data = '0;
    rec_data[PER_LSB +: PER_W] = period_reg;
    rec_data[IDX_LSB +: IDX_W] = idx_reg;
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rec_push),
    .pop   (evt_ready),
    .din   (rec_data),
    .head  (evt_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign evt_valid = !fifo_empty;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_cnt_wrap_monitor.sv
// Bench for cnt_wrap_monitor: directed wrap/FIFO scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_cnt_wrap_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  cnt_in;
  logic        ovf_clr;
  logic        evt_valid;
  logic        evt_ready;
  logic [23:0] evt_data;
  logic [2:0]  fifo_level;
  logic        overflow;

  always #5 clk = ~clk;

  cnt_wrap_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cnt_in     (cnt_in),
    .ovf_clr    (ovf_clr),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          fr      = 0;
  int          valid_cycles = 0;
  logic [23:0] got_q[$];

  // Reference model: records waiting for the consumer, plus the monitor's bookkeeping.
  logic [23:0] m_q[$];
  logic [7:0]  m_idx   = 0;
  int          m_per   = 0;
  int          m_seen  = 0;
  bit          m_synced = 0;
  logic [4:0]  m_prev  = 0;
  bit          m_ovf   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit pop;
    bit wrap;
    bit dropped;
    if (rst) begin
      m_q.delete();
      m_idx = 0; m_per = 0; m_seen = 0; m_synced = 0; m_prev = 0; m_ovf = 0;
      return;
    end
    pop     = evt_ready && (m_q.size() > 0);
    wrap    = (cnt_in < m_prev);
    dropped = 0;
    if (pop) void'(m_q.pop_front());
    if (!en) begin
      m_seen = 0; m_synced = 0; m_per = 0;
    end else if (m_seen < 2) begin
      m_seen++;
    end else if (!m_synced) begin
      if (wrap) begin
        m_synced = 1;
        m_per = 1;
      end
    end else if (wrap) begin
      if (m_q.size() >= 4) dropped = 1;
      else m_q.push_back({m_idx, 16'(m_per)});
      m_idx++;
      m_per = 1;
    end else if (m_per < 65535) begin
      m_per++;
    end
    if (dropped) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_prev = cnt_in;
  endtask

  task automatic compare_all();
    check("valid", evt_valid, m_q.size() != 0);
    check("level", fifo_level, m_q.size());
    check("overflow", overflow, m_ovf);
    if (m_q.size() != 0) check("data", evt_data, m_q[0]);
  endtask

  task automatic tick();
    model_step();
    if (!rst && evt_valid && evt_ready) begin
      got_q.push_back(evt_data);
      $display("pop idx=%0d period=%0d level=%0d", evt_data[23:16], evt_data[15:0], fifo_level);
    end
    if (evt_valid) valid_cycles++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) begin
      cnt_in = 5'(fr);
      tick();
      fr = (fr + 1) % 32;
    end
  endtask

  task automatic run_until(input int nrec, input int bound, input string tag);
    int c = 0;
    while (got_q.size() < nrec && c < bound) begin
      free(1);
      c++;
    end
    check({tag, "_records"}, got_q.size(), nrec);
  endtask

  initial begin
    int h;
    int seq2[21] = '{20, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 17, 0, 1, 5, 9, 9, 9, 10, 11};
    int ready_pct;
    int r;

    rst = 1; en = 0; ovf_clr = 0; evt_ready = 0; cnt_in = 0;
    tick();
    check("rst_valid", evt_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", evt_data, 0);

    // Free-running counter: sync wrap dropped, then full 32-cycle periods.
    rst = 0; en = 1; evt_ready = 1; fr = 5;
    got_q.delete(); valid_cycles = 0;
    run_until(3, 200, "s1");
    check("s1_rec0", got_q[0], {8'd0, 16'd32});
    check("s1_rec1", got_q[1], {8'd1, 16'd32});
    check("s1_rec2", got_q[2], {8'd2, 16'd32});
    check("s1_pulse", valid_cycles, 3);

    // Short period from a jump, then a stalled counter.
    got_q.delete();
    foreach (seq2[i]) begin
      cnt_in = 5'(seq2[i]);
      tick();
    end
    fr = 12;
    check("s2_records", got_q.size(), 2);
    check("s2_idx0", got_q[0][23:16], 3);
    check("s2_rec1", got_q[1], {8'd4, 16'd12});

    // Overflow with the consumer stalled over six wraps.
    rst = 1; cnt_in = 0; tick();
    rst = 0; evt_ready = 0; fr = 0; got_q.delete();
    free(230);
    check("s3_level", fifo_level, 4);
    check("s3_ovf", overflow, 1);
    check("s3_head", evt_data[23:16], 0);
    evt_ready = 1;
    run_until(5, 60, "s3");
    for (int i = 0; i < 4; i++) check($sformatf("s3_idx%0d", i), got_q[i][23:16], i);
    check("s3_gap", got_q[4][23:16], 6);
    ovf_clr = 1; free(1); ovf_clr = 0;
    check("s3_ovfclr", overflow, 0);

    // Full FIFO with a pop in the wrap cycle.
    evt_ready = 0;
    for (int c = 0; c < 200 && m_q.size() < 4; c++) free(1);
    while (fr != 0) free(1);
    h = int'(evt_data[23:16]);
    check("s4_head0", h, 7);
    evt_ready = 1; free(1); evt_ready = 0;
    check("s4_level", fifo_level, 4);
    check("s4_ovf", overflow, 0);
    check("s4_head1", evt_data[23:16], 8);

    // Reset mid-run with three queued records.
    evt_ready = 1; free(1); evt_ready = 0;
    check("s5_level3", fifo_level, 3);
    rst = 1; cnt_in = 5'(fr); tick(); rst = 0;
    check("s5_valid", evt_valid, 0);
    check("s5_level", fifo_level, 0);
    check("s5_ovf", overflow, 0);
    evt_ready = 1; got_q.delete();
    run_until(1, 120, "s5");
    check("s5_idx", got_q[0][23:16], 0);

    // Disable for ten cycles: re-sync, index continues.
    run_until(2, 60, "s6pre");
    en = 0; free(10); en = 1;
    got_q.delete();
    run_until(1, 120, "s6");
    check("s6_rec", got_q[0], {8'd2, 16'd32});

    // Random traffic against the model.
    ready_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) ready_pct = $urandom_range(0, 100);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      r = $urandom_range(0, 9);
      if (r == 0) fr = $urandom_range(0, 31);
      else if (r != 1) fr = (fr + 1) % 32;
      cnt_in = 5'(fr);
      evt_ready = ($urandom_range(0, 99) < ready_pct);
      ovf_clr = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
